// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Detects load-use hazards, taken branches and data-memory wait states and
// drives the enable / synchronous-clear inputs of every pipeline register.
// A small RUN/WAIT/ERR machine tracks outstanding memory accesses and raises
// a sticky error if the memory stays busy for too long. Two saturating
// counters record stall cycles for performance debug.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic                  mem_err,
    output logic [15:0]           lu_stall_cnt,
    output logic [15:0]           mem_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [15:0] CNT_MAX_C = 16'hFFFF;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] wait_cnt_r;
    logic [15:0] wait_cnt_nxt_s;
    logic        mem_err_r;
    logic [15:0] lu_cnt_r;
    logic [15:0] ms_cnt_r;

    logic        freeze_s;
    logic        load_use_s;
    logic        bubble_s;

    // Hazard detection: memory freeze (busy access or error) and load-use match.
    always_comb begin
        freeze_s   = (mem_req & ~mem_ready) | (state_r == ST_ERR);
        load_use_s = ex_mem_read & (ex_rd != {REG_ADDR_W{1'b0}}) &
                     ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
        // A bubble is only really inserted when nothing of higher priority wins.
        bubble_s   = load_use_s & ~freeze_s & ~ex_branch_taken;
    end

    // Pipeline register enables/flushes, highest-priority condition first.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (freeze_s) begin
            // Whole pipeline holds; a taken branch stays in EX until release.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (ex_branch_taken) begin
            // Both younger instructions are wrong-path, including a stalled one.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use_s) begin
            // Hold PC and IF/ID, push a bubble into ID/EX.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else begin
            pc_en = 1'b1;
        end
    end

    // Memory-access tracking: next state and wait counter.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nxt_s    = ST_WAIT;
                    wait_cnt_nxt_s = 16'd1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT: begin
                // A dropped mem_req without mem_ready still counts as busy.
                if (mem_ready) begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = 16'd0;
                end else if (wait_cnt_r == TIMEOUT_C) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 16'd1;
                end
            end
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
            default: begin
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = 16'd0;
            end
        endcase
    end

    // State, wait counter and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 16'd0;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            mem_err_r  <= (state_nxt_s == ST_ERR);
        end
    end

    // Saturating performance counters for load-use bubbles and memory freezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_r <= 16'd0;
            ms_cnt_r <= 16'd0;
        end else begin
            if (bubble_s && (lu_cnt_r != CNT_MAX_C)) begin
                lu_cnt_r <= lu_cnt_r + 16'd1;
            end
            if (freeze_s && (ms_cnt_r != CNT_MAX_C)) begin
                ms_cnt_r <= ms_cnt_r + 16'd1;
            end
        end
    end

    assign mem_err       = mem_err_r;
    assign lu_stall_cnt  = lu_cnt_r;
    assign mem_stall_cnt = ms_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_pipe_hazard_ctrl;

    localparam int RW = 5;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs, id_rt, ex_rd;
    logic          id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic          mem_err;
    logic [15:0]   lu_stall_cnt, mem_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pending access, stalled-cycle count, error, counters.
    bit m_err;
    bit m_pending;
    int m_stalled;
    int m_lu;
    int m_ms;

    pipe_hazard_ctrl #(.REG_ADDR_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .mem_err(mem_err), .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_load_use();
        return ex_mem_read && (ex_rd != 0) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    endfunction

    function automatic bit m_freeze();
        return (mem_req && !mem_ready) || m_err;
    endfunction

    // Expected {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes}.
    function automatic logic [8:0] m_ctrl();
        if (rst)                  return 9'b00000_1111;
        else if (m_freeze())      return 9'b00000_0000;
        else if (ex_branch_taken) return 9'b11111_1100;
        else if (m_load_use())    return 9'b00111_0100;
        else                      return 9'b11111_0000;
    endfunction

    // Check the current cycle, advance the model, then move past the clock edge.
    task automatic cycle();
        bit frz;
        bit lu;
        #2;
        check("ctrl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, memwb_flush}, m_ctrl());
        check("mem_err", mem_err, m_err);
        check("lu_cnt", lu_stall_cnt, m_lu);
        check("ms_cnt", mem_stall_cnt, m_ms);
        if (rst) begin
            m_err = 0; m_pending = 0; m_stalled = 0; m_lu = 0; m_ms = 0;
        end else begin
            frz = m_freeze();
            lu  = m_load_use();
            if (frz && m_ms < 65535) m_ms++;
            if (!frz && !ex_branch_taken && lu && m_lu < 65535) m_lu++;
            if (!m_err) begin
                if (!m_pending) begin
                    if (mem_req && !mem_ready) begin
                        m_pending = 1;
                        m_stalled = 1;
                    end
                end else if (mem_ready) begin
                    m_pending = 0;
                end else begin
                    m_stalled++;
                end
                if (m_pending && m_stalled == TO + 1) begin
                    m_err = 1;
                    m_pending = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rt = 0;
        ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        m_err = 0; m_pending = 0; m_stalled = 0; m_lu = 0; m_ms = 0;
        @(posedge clk);
        #1;
        cycle();
        cycle();

        // Load r8 in EX, ID reads rs=8: one bubble, then normal flow.
        idle_inputs();
        ex_mem_read = 1; ex_rd = 8; id_rs = 8;
        cycle();
        ex_mem_read = 0;
        cycle();
        check("lu_after_one", lu_stall_cnt, 32'd1);

        // No stall for r0 destination or an rt match the instruction ignores.
        ex_mem_read = 1; ex_rd = 0; id_rs = 0;
        cycle();
        ex_rd = 8; id_rs = 3; id_rt = 8; id_uses_rt = 0;
        cycle();
        id_uses_rt = 1;
        cycle();

        // Taken branch overrides a load-use hazard.
        idle_inputs();
        ex_mem_read = 1; ex_rd = 5; id_rs = 5; ex_branch_taken = 1;
        cycle();
        check("lu_branch_override", lu_stall_cnt, 32'd2);

        // Memory busy three cycles with a branch held in EX, released on the fourth.
        idle_inputs();
        ex_branch_taken = 1; mem_req = 1;
        repeat (3) cycle();
        mem_ready = 1;
        cycle();
        check("ms_after_wait", mem_stall_cnt, 32'd3);
        idle_inputs();
        cycle();

        // Memory never ready: error after TIMEOUT+1 stalled cycles, cleared by rst.
        mem_req = 1;
        repeat (8) cycle();
        check("err_sticky", mem_err, 32'd1);
        idle_inputs();
        repeat (3) cycle();
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        check("err_cleared", mem_err, 32'd0);
        check("ms_cleared", mem_stall_cnt, 32'd0);

        // Randomized traffic; memory request held while an access is outstanding.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0) || (m_err && ($urandom_range(0, 3) == 0));
            id_rs = RW'($urandom_range(0, 3));
            id_rt = RW'($urandom_range(0, 3));
            ex_rd = RW'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            if (m_pending) begin
                mem_req = 1;
                mem_ready = ($urandom_range(0, 2) == 0);
            end else begin
                mem_req = ($urandom_range(0, 3) == 0);
                mem_ready = 1'($urandom_range(0, 1));
            end
            cycle();
        end

        // Saturation of the load-use counter.
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
        ex_mem_read = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1;
        repeat (70000) cycle();
        check("lu_saturated", lu_stall_cnt, 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
